hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline interlock and branch-flush control for a 5-stage MIPS-style core.
// Tracks in-flight destinations in a 3-slot shadow pipeline (EX, MEM, WB).
// Optional feature: define HAZARD_UNIT_FORWARD_EN when the datapath forwards results,
// leaving only load-use as a stalling hazard.
`timescale 1ns/1ps
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        mem_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush,
  output logic [15:0] stall_count
);

  localparam int unsigned OPW  = 6;
  localparam int unsigned REGW = 5;
  localparam int unsigned CNTW = 16;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_NOP   = 6'b100000;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            is_load;
    logic [REGW-1:0] dst;
  } slot_t;

  slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  slot_t id_entry;
  logic [CNTW-1:0] stall_count_q, stall_count_d;

  logic use_rs, use_rt;
  logic hazard;
  logic stall_c, flush_c;
  logic unused_wb;

  // Decode the ID instruction into source usage and a shadow-slot entry
  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    id_entry = '0;
    if (id_valid) begin
      id_entry.valid = 1'b1;
      case (id_opcode)
        OP_RTYPE: begin
          use_rs            = 1'b1;
          use_rt            = 1'b1;
          id_entry.regwrite = (id_rd != '0);
          id_entry.dst      = id_rd;
        end
        OP_LW: begin
          use_rs            = 1'b1;
          id_entry.regwrite = (id_rt != '0);
          id_entry.is_load  = 1'b1;
          id_entry.dst      = id_rt;
        end
        OP_SW, OP_BEQ: begin
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        OP_NOP:  ;
        default: ;
      endcase
    end
  end

  // Compare ID sources against in-flight destinations; WB never conflicts
  always_comb begin
    logic ex_hit;
    ex_hit = ex_q.valid && ex_q.regwrite &&
             ((use_rs && (ex_q.dst == id_rs)) || (use_rt && (ex_q.dst == id_rt)));
`ifdef HAZARD_UNIT_FORWARD_EN
    hazard = ex_hit && ex_q.is_load;
`else
    hazard = ex_hit ||
             (mem_q.valid && mem_q.regwrite &&
              ((use_rs && (mem_q.dst == id_rs)) || (use_rt && (mem_q.dst == id_rt))));
`endif
  end

  // Control outputs: reset forces normal flow, flush outranks stall
  always_comb begin
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;
    if (!rst) begin
      if (mem_branch_taken) begin
        flush_c     = 1'b1;
        flush       = 1'b1;
        idex_bubble = 1'b1;
      end else if (hazard) begin
        stall_c     = 1'b1;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Next shadow-pipeline contents and saturating stall counter
  always_comb begin
    wb_d          = mem_q;
    mem_d         = flush_c ? slot_t'('0) : ex_q;
    ex_d          = (stall_c || flush_c) ? slot_t'('0) : id_entry;
    stall_count_d = stall_count_q;
    if (stall_c && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNTW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  // WB slot only retires entries; it is kept to mirror the real pipeline depth
  always_comb begin
    unused_wb = ^wb_q;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit against a register-history model.
`timescale 1ns/1ps
module tb_hazard_unit;

`ifdef HAZARD_UNIT_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] NOP = 6'b100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  id_opcode = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        mem_branch_taken = 1'b0;
  logic        pc_write, ifid_write, idex_bubble, flush;
  logic [15:0] stall_count;

  int n_pass  = 0;
  int n_total = 0;

  // Model: register written by the instruction now in EX / MEM (0 = none)
  int m_ex_dst  = 0;
  bit m_ex_ld   = 0;
  int m_mem_dst = 0;
  int m_cnt     = 0;
  int forced    = 0;
  int obs_bub   = 0;

  hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_branch_taken(mem_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush(flush), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Sources read (-1 = none) and register written (0 = none) per the ISA rules
  function automatic void ref_decode(input bit v, input logic [5:0] op,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd,
                                     output int s1, output int s2, output int d, output bit ld);
    s1 = -1; s2 = -1; d = 0; ld = 1'b0;
    if (v) begin
      case (op)
        RT:      begin s1 = int'(rs); s2 = int'(rt); d = int'(rd); end
        LW:      begin s1 = int'(rs); d = int'(rt); ld = 1'b1; end
        SW, BEQ: begin s1 = int'(rs); s2 = int'(rt); end
        default: ;
      endcase
    end
  endfunction

  function automatic bit reads(input int s1, input int s2, input int dst);
    return (dst != 0) && ((dst == s1) || (dst == s2));
  endfunction

  // One clock: drive at negedge, compare shortly after, then advance the model
  task automatic step(input bit r, input bit v, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input bit br, input bit do_chk);
    int s1, s2, d;
    bit ld, haz, stl, fl;
    @(negedge clk);
    rst = r; id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    mem_branch_taken = br;
    #1;
    ref_decode(v, op, rs, rt, rd, s1, s2, d, ld);
    if (FWD) haz = m_ex_ld && reads(s1, s2, m_ex_dst);
    else     haz = reads(s1, s2, m_ex_dst) || reads(s1, s2, m_mem_dst);
    fl  = br && !r;
    stl = haz && !br && !r;
    if (do_chk) begin
      chk("pc_write",    16'(pc_write),    16'(!stl));
      chk("ifid_write",  16'(ifid_write),  16'(!stl));
      chk("idex_bubble", 16'(idex_bubble), 16'(stl || fl));
      chk("flush",       16'(flush),       16'(fl));
      chk("stall_count", stall_count,      16'(m_cnt));
    end
    if (idex_bubble) obs_bub++;
    if (r) begin
      m_ex_dst = 0; m_ex_ld = 1'b0; m_mem_dst = 0; m_cnt = 0;
    end else begin
      m_mem_dst = br ? 0 : m_ex_dst;
      if (stl || fl) begin m_ex_dst = 0; m_ex_ld = 1'b0; end
      else begin m_ex_dst = d; m_ex_ld = ld; end
      if (stl) begin
        forced++;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    obs_bub = 0;
  endtask

  initial begin
    int guard;
    // Reset overrides a pending branch flush
    step(1'b1, 1'b1, LW, 5'd1, 5'd8, 5'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, LW, 5'd1, 5'd8, 5'd0, 1'b1, 1'b1);
    chk("rst_flush", 16'(flush), 16'd0);
    chk("rst_pc_write", 16'(pc_write), 16'd1);
    chk("rst_count", stall_count, 16'd0);

    // Load-use: LW $8 then RTYPE reading $8
    do_reset();
    step(1'b0, 1'b1, LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1, RT, 5'd8, 5'd0, 5'd9, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("lu_bubbles", 16'(obs_bub), FWD ? 16'd1 : 16'd2);
    chk("lu_count", stall_count, FWD ? 16'd1 : 16'd2);

    // ALU result consumed by a store
    do_reset();
    step(1'b0, 1'b1, RT, 5'd1, 5'd2, 5'd9, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1, SW, 5'd0, 5'd9, 5'd0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("sw_bubbles", 16'(obs_bub), FWD ? 16'd0 : 16'd2);
    chk("sw_count", stall_count, FWD ? 16'd0 : 16'd2);

    // Writes to $0 never create a dependency
    do_reset();
    step(1'b0, 1'b1, RT, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, RT, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
    step(1'b0, 1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("r0_bubbles", 16'(obs_bub), 16'd0);
    chk("r0_count", stall_count, 16'd0);

    // Flush in the same cycle as a load-use hazard in EX
    do_reset();
    step(1'b0, 1'b1, LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, RT, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1);
    chk("fl_flush", 16'(flush), 16'd1);
    chk("fl_pc_write", 16'(pc_write), 16'd1);
    chk("fl_ifid_write", 16'(ifid_write), 16'd1);
    chk("fl_count", stall_count, 16'd0);
    step(1'b0, 1'b1, RT, 5'd8, 5'd0, 5'd9, 1'b0, 1'b1);
    chk("fl_ex_cleared", 16'(idex_bubble), 16'd0);
    chk("fl_count_after", stall_count, 16'd0);

    // Flush while the producer sits in MEM
    do_reset();
    step(1'b0, 1'b1, LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, RT, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1);
    step(1'b0, 1'b1, RT, 5'd8, 5'd0, 5'd9, 1'b0, 1'b1);
    chk("fl_mem_cleared", 16'(idex_bubble), 16'd0);

    // Reset mid-stall abandons the stall and clears the counter
    do_reset();
    step(1'b0, 1'b1, LW, 5'd1, 5'd8, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, RT, 5'd8, 5'd0, 5'd9, 1'b0, 1'b1);
    chk("ms_stall", 16'(idex_bubble), 16'd1);
    step(1'b1, 1'b1, RT, 5'd8, 5'd0, 5'd9, 1'b0, 1'b1);
    chk("ms_rst_bubble", 16'(idex_bubble), 16'd0);
    step(1'b0, 1'b1, RT, 5'd8, 5'd0, 5'd9, 1'b0, 1'b1);
    chk("ms_after_bubble", 16'(idex_bubble), 16'd0);
    chk("ms_after_count", stall_count, 16'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = RT;
        1: op = LW;
        2: op = SW;
        3: op = BEQ;
        4: op = NOP;
        default: op = 6'($urandom_range(0, 63));
      endcase
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0, op,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) == 0, 1'b1);
    end

    // Saturation: a self-dependent load keeps re-stalling
    do_reset();
    forced = 0;
    guard  = 0;
    while (forced < 65540 && guard < 200000) begin
      step(1'b0, 1'b1, LW, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
      guard++;
    end
    chk("sat_reached", 16'(forced >= 65540), 16'd1);
    chk("sat_count", stall_count, 16'hFFFF);
    step(1'b0, 1'b1, LW, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, LW, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
    chk("sat_hold", stall_count, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
